// File: rtl/ultra_cmd_tx.sv
// Encodes host requests into 15-bit controller command words and keeps order/image/DAC tracking.
// Each word is held HOLD_CYCLES cycles, then a one-cycle zero gap; power_off preempts everything.
module ultra_cmd_tx #(
  parameter int DATA_WIDTH     = 15,
  parameter int MAX_ORDERS     = 5,
  parameter int IMGS_PER_ORDER = 50,
  parameter int HOLD_CYCLES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [7:0]            req_amount,
  output logic                  req_ready,
  input  logic                  power_off,
  input  logic                  img_done,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_strobe,
  output logic [2:0]            outstanding,
  output logic [11:0]           dac_shadow,
  output logic                  err_sticky
);

  localparam int IW = $clog2(IMGS_PER_ORDER);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CAP  = 2'b11;

  // Flag bits 6:0 = valid, send, receive, decrease, increase, off, on
  localparam logic [6:0] F_HOLD = 7'b1100001;
  localparam logic [6:0] F_INC  = 7'b1100101;
  localparam logic [6:0] F_DEC  = 7'b1101001;
  localparam logic [6:0] F_CAP  = 7'b1010001;
  localparam logic [6:0] F_OFF  = 7'b1000010;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            hold_cnt, hold_cnt_nxt;
  logic [DATA_WIDTH-1:0] word, word_nxt, enc_word;
  logic                  strobe_nxt;
  logic [IW-1:0]         img_cnt, img_cnt_nxt;
  logic [2:0]            outstanding_nxt;
  logic [11:0]           dac_nxt;
  logic                  admissible, accept, order_inc, img_ok, retire;

  assign img_ok = img_done && (outstanding != 3'd0);
  assign retire = img_ok && (img_cnt == IW'(IMGS_PER_ORDER - 1));

  // An order retiring this very cycle frees its slot, so a new order may take it.
  always_comb begin
    admissible = 1'b0;
    if (req_op == OP_CAP) admissible = (outstanding != 3'd0);
    else                  admissible = (outstanding < 3'(MAX_ORDERS)) || retire;
  end

  assign req_ready = rst_n && (state == IDLE) && !power_off && admissible;
  assign accept    = req_valid && req_ready;
  assign order_inc = accept && (req_op != OP_CAP);

  always_comb begin
    enc_word = '0;
    case (req_op)
      OP_HOLD: enc_word = DATA_WIDTH'({8'd0, F_HOLD});
      OP_INC:  enc_word = DATA_WIDTH'({req_amount, F_INC});
      OP_DEC:  enc_word = DATA_WIDTH'({req_amount, F_DEC});
      default: enc_word = DATA_WIDTH'({8'd0, F_CAP});
    endcase
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    word_nxt     = word;
    strobe_nxt   = 1'b0;
    if (power_off) begin
      state_nxt    = SEND;
      hold_cnt_nxt = '0;
      word_nxt     = DATA_WIDTH'({8'd0, F_OFF});
      strobe_nxt   = 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_nxt    = SEND;
          hold_cnt_nxt = '0;
          word_nxt     = enc_word;
          strobe_nxt   = 1'b1;
        end
        SEND: begin
          if (hold_cnt == 4'(HOLD_CYCLES - 1)) state_nxt = GAP;
          else                                 hold_cnt_nxt = hold_cnt + 4'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    outstanding_nxt = outstanding;
    img_cnt_nxt     = img_cnt;
    dac_nxt         = dac_shadow;
    if (power_off) begin
      outstanding_nxt = '0;
      img_cnt_nxt     = '0;
      dac_nxt         = '0;
    end else begin
      case ({order_inc, retire})
        2'b10:   outstanding_nxt = outstanding + 3'd1;
        2'b01:   outstanding_nxt = outstanding - 3'd1;
        default: outstanding_nxt = outstanding;
      endcase
      if (retire)      img_cnt_nxt = '0;
      else if (img_ok) img_cnt_nxt = img_cnt + IW'(1);
      if (accept && req_op == OP_INC) dac_nxt = dac_shadow + {req_amount, 4'd0};
      if (accept && req_op == OP_DEC) dac_nxt = dac_shadow - {req_amount, 4'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      word        <= '0;
      cmd_strobe  <= 1'b0;
      img_cnt     <= '0;
      outstanding <= '0;
      dac_shadow  <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      word        <= word_nxt;
      cmd_strobe  <= strobe_nxt;
      img_cnt     <= img_cnt_nxt;
      outstanding <= outstanding_nxt;
      dac_shadow  <= dac_nxt;
      if (img_done && outstanding == 3'd0) err_sticky <= 1'b1;
    end
  end

  assign cmd_data = (state == SEND) ? word : '0;

endmodule

// File: tb/tb_ultra_cmd_tx.sv
// Directed bench for ultra_cmd_tx: inputs change and outputs are sampled 1ns after each rising edge.
module tb_ultra_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [7:0]  req_amount;
  logic        req_ready;
  logic        power_off;
  logic        img_done;
  logic [14:0] cmd_data;
  logic        cmd_strobe;
  logic [2:0]  outstanding;
  logic [11:0] dac_shadow;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ultra_cmd_tx dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_amount(req_amount), .req_ready(req_ready),
    .power_off(power_off), .img_done(img_done),
    .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
    .outstanding(outstanding), .dac_shadow(dac_shadow), .err_sticky(err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for it to be accepted; returns 1ns after the accept edge.
  task automatic send(input logic [1:0] op, input logic [7:0] amt);
    bit done = 0;
    req_valid = 1'b1; req_op = op; req_amount = amt;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (req_ready) done = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      img_done = 1'b1;
      tick();
      img_done = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_amount = 8'd0;
    power_off = 1'b0; img_done = 1'b0;
    tick(); tick();
    chk("rst_cmd", 32'(cmd_data), 32'h0);
    chk("rst_strobe", 32'(cmd_strobe), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_dac", 32'(dac_shadow), 32'h0);
    chk("rst_err", 32'(err_sticky), 32'h0);
    req_valid = 1'b0; rst_n = 1'b1;
    tick();

    // Increase by 3
    req_valid = 1'b1; req_op = 2'b01; req_amount = 8'd3;
    #1 chk("inc_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0;
    chk("inc_cmd1", 32'(cmd_data), 32'h01E5);
    chk("inc_strobe1", 32'(cmd_strobe), 32'h1);
    chk("inc_dac", 32'(dac_shadow), 32'd48);
    chk("inc_outstanding", 32'(outstanding), 32'd1);
    req_valid = 1'b1; req_op = 2'b00;
    #1 chk("send_ready_low", 32'(req_ready), 32'h0);
    tick();
    chk("inc_cmd2", 32'(cmd_data), 32'h01E5);
    chk("inc_strobe2", 32'(cmd_strobe), 32'h0);
    tick();
    chk("gap_cmd", 32'(cmd_data), 32'h0);
    chk("gap_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1;
    #1 chk("idle_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b0;

    // Image retirement: 49 pulses keep the order, the 50th retires it
    pulses(49);
    chk("img49_outstanding", 32'(outstanding), 32'd1);
    chk("img49_cnt", 32'(dut.img_cnt), 32'd49);
    pulses(1);
    chk("img50_outstanding", 32'(outstanding), 32'd0);
    chk("img50_cnt", 32'(dut.img_cnt), 32'd0);

    // Capture not admissible with nothing outstanding, and no error
    req_valid = 1'b1; req_op = 2'b11;
    #1 chk("cap_zero_ready", 32'(req_ready), 32'h0);
    tick();
    req_valid = 1'b0;
    chk("cap_zero_err", 32'(err_sticky), 32'h0);
    chk("cap_zero_cmd", 32'(cmd_data), 32'h0);

    pulses(1);
    chk("err_set", 32'(err_sticky), 32'h1);
    chk("err_outstanding", 32'(outstanding), 32'd0);

    // Fill to the order limit
    for (int k = 0; k < 5; k++) begin
      send(2'b00, 8'd0);
      chk("hold_cmd", 32'(cmd_data), 32'h0061);
    end
    chk("full_outstanding", 32'(outstanding), 32'd5);
    req_valid = 1'b1; req_op = 2'b00;
    tick(); tick(); tick();
    chk("full_ready", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    send(2'b11, 8'd0);
    chk("cap_cmd", 32'(cmd_data), 32'h0051);
    chk("cap_strobe", 32'(cmd_strobe), 32'h1);
    chk("cap_outstanding", 32'(outstanding), 32'd5);

    // Hold accepted in the same cycle a 50th image retires an order
    pulses(49);
    chk("full49_outstanding", 32'(outstanding), 32'd5);
    req_valid = 1'b1; req_op = 2'b00; img_done = 1'b1;
    #1 chk("swap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0; img_done = 1'b0;
    chk("swap_outstanding", 32'(outstanding), 32'd5);
    chk("swap_cnt", 32'(dut.img_cnt), 32'd0);
    chk("swap_cmd", 32'(cmd_data), 32'h0061);

    // Clear via power_off, then decrease wraps the DAC shadow
    power_off = 1'b1;
    tick();
    power_off = 1'b0;
    chk("off1_cmd", 32'(cmd_data), 32'h0042);
    chk("off1_dac", 32'(dac_shadow), 32'h0);
    send(2'b10, 8'd1);
    chk("dec_cmd", 32'(cmd_data), 32'h00E9);
    chk("dec_dac", 32'(dac_shadow), 32'hFF0);
    chk("dec_outstanding", 32'(outstanding), 32'd1);

    // power_off mid-SEND with a competing request
    power_off = 1'b1; req_valid = 1'b1; req_op = 2'b00;
    #1 chk("off_ready", 32'(req_ready), 32'h0);
    tick();
    power_off = 1'b0; req_valid = 1'b0;
    chk("off2_cmd", 32'(cmd_data), 32'h0042);
    chk("off2_strobe", 32'(cmd_strobe), 32'h1);
    chk("off2_outstanding", 32'(outstanding), 32'd0);
    chk("off2_dac", 32'(dac_shadow), 32'h0);
    chk("off2_err", 32'(err_sticky), 32'h1);
    tick();
    chk("off3_cmd", 32'(cmd_data), 32'h0042);
    chk("off3_strobe", 32'(cmd_strobe), 32'h0);
    tick();
    chk("off_gap_cmd", 32'(cmd_data), 32'h0);

    // Reset mid-word: word dropped, error cleared
    send(2'b01, 8'd2);
    chk("pre_rst_cmd", 32'(cmd_data), 32'h0165);
    rst_n = 1'b0;
    tick();
    chk("midrst_cmd", 32'(cmd_data), 32'h0);
    chk("midrst_err", 32'(err_sticky), 32'h0);
    chk("midrst_outstanding", 32'(outstanding), 32'd0);
    chk("midrst_dac", 32'(dac_shadow), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("postrst_cmd", 32'(cmd_data), 32'h0);
    chk("postrst_strobe", 32'(cmd_strobe), 32'h0);
    tick();
    chk("postrst_cmd2", 32'(cmd_data), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
